// File: rtl/pipelined_adder_sub.sv
// WIDTH-bit add/subtract unit with the carry chain split into STAGES registered
// chunks and valid/ready handshakes on both sides; bubbles collapse under stalls.
module pipelined_adder_sub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // Per-stage registers: delayed operands (B already inverted), partial sum, chunk carry
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  sa [STAGES];
  logic [WIDTH-1:0]  sb [STAGES];
  logic [WIDTH-1:0]  ps [STAGES];
  logic [STAGES-1:0] cr;
  logic              ovf_q;

  // Next values presented to each stage
  logic [WIDTH-1:0]  na [STAGES];
  logic [WIDTH-1:0]  nb [STAGES];
  logic [WIDTH-1:0]  np [STAGES];
  logic [STAGES-1:0] nc;
  logic [STAGES-1:0] nv;
  logic [STAGES-1:0] rdy;
  logic              all_full;
  logic              ovf_nx;

  // Ready chain: a stage can load if it, or anything downstream, has room
  always_comb begin
    all_full = 1'b1;
    rdy      = '0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      all_full       = all_full & vld[LAST-j];
      rdy[LAST-j]    = out_ready | ~all_full;
    end
  end

  // Chunk adders: stage 0 takes the ports, later stages take the prior stage
  always_comb begin
    na[0] = a;
    nb[0] = sub ? ~b : b;
    nv[0] = in_valid;
    np[0] = '0;
    {nc[0], np[0][CW-1:0]} = {1'b0, a[CW-1:0]} + {1'b0, nb[0][CW-1:0]}
                           + (CW+1)'(sub | cin);
    for (int unsigned i = 1; i < STAGES; i++) begin
      na[i] = sa[i-1];
      nb[i] = sb[i-1];
      nv[i] = vld[i-1];
      np[i] = ps[i-1];
      {nc[i], np[i][i*CW +: CW]} = {1'b0, sa[i-1][i*CW +: CW]}
                                 + {1'b0, sb[i-1][i*CW +: CW]}
                                 + (CW+1)'(cr[i-1]);
    end
    ovf_nx = (na[LAST][WIDTH-1] == nb[LAST][WIDTH-1])
          && (np[LAST][WIDTH-1] != na[LAST][WIDTH-1]);
  end

  // Data only moves with a valid beat so the output holds its last result
  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= '0;
      cr    <= '0;
      ovf_q <= 1'b0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        sa[i] <= '0;
        sb[i] <= '0;
        ps[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (rdy[i]) begin
          vld[i] <= nv[i];
          if (nv[i]) begin
            sa[i] <= na[i];
            sb[i] <= nb[i];
            ps[i] <= np[i];
            cr[i] <= nc[i];
          end
        end
      end
      if (rdy[LAST] && nv[LAST]) ovf_q <= ovf_nx;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[LAST];
  assign sum       = ps[LAST];
  assign cout      = cr[LAST];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Bench for pipelined_adder_sub: 16-bit/4-stage instance against a queue model,
// plus an 8-bit/1-stage instance swept over a dense operand grid.
module tb_pipelined_adder_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [15:0] a = '0, b = '0, sum;
  logic        cin = 1'b0, sub = 1'b0, cout, ovf;

  logic        in_valid8 = 1'b0, in_ready8, out_valid8;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        cin8 = 1'b0, sub8 = 1'b0, cout8, ovf8;

  int total = 0, bad = 0;
  int nout = 0, nacc = 0, nacc8 = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  pipelined_adder_sub #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

  pipelined_adder_sub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(1'b1), .sum(sum8), .cout(cout8), .ovf(ovf8));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Arithmetic reference: {ovf, cout, sum[31:0]} from integer values
  function automatic logic [33:0] ref_op(input int w, input longint ua, input longint ub,
                                         input bit c, input bit s);
    longint modv, half, sva, svb, full, sres;
    logic [33:0] r;
    modv = 1;
    modv = modv << w;
    half = modv / 2;
    sva  = (ua >= half) ? ua - modv : ua;
    svb  = (ub >= half) ? ub - modv : ub;
    if (!s) begin
      full = ua + ub + longint'(c);
      sres = sva + svb + longint'(c);
    end else begin
      full = ua + (modv - ub);
      sres = sva - svb;
    end
    r[31:0] = 32'(full % modv);
    r[32]   = (full >= modv);
    r[33]   = (sres >= half) || (sres < -half);
    return r;
  endfunction

  // Scoreboard for the 16-bit instance
  logic [33:0] q[$];
  logic [33:0] e;
  bit          held_v = 1'b0;
  logic [17:0] held;

  always @(negedge clk) begin
    if (armed) begin
      if (rst) begin
        q.delete();
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", {14'd0, ovf, cout, sum}, {14'd0, held});
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 32'(out_valid), 32'd0);
          end else begin
            e = q.pop_front();
            chk("sum", 32'(sum), 32'(e[15:0]));
            chk("cout", 32'(cout), 32'(e[32]));
            chk("ovf", 32'(ovf), 32'(e[33]));
          end
          nout++;
        end
        held_v = out_valid && !out_ready;
        held   = {ovf, cout, sum};
        if (in_valid && in_ready) begin
          q.push_back(ref_op(16, longint'(a), longint'(b), cin, sub));
          nacc++;
        end
      end
    end
  end

  // Fixed one-cycle latency model for the 8-bit instance
  bit          prev_acc = 1'b0;
  logic [33:0] prev_e;

  always @(negedge clk) begin
    if (armed) begin
      if (rst) begin
        prev_acc = 1'b0;
      end else begin
        chk("v8_out_valid", 32'(out_valid8), 32'(prev_acc));
        if (prev_acc) begin
          chk("v8_sum", 32'(sum8), 32'(prev_e[7:0]));
          chk("v8_cout", 32'(cout8), 32'(prev_e[32]));
          chk("v8_ovf", 32'(ovf8), 32'(prev_e[33]));
        end
        if (in_valid8) chk("v8_in_ready", 32'(in_ready8), 32'd1);
        prev_acc = in_valid8 && in_ready8;
        prev_e   = ref_op(8, longint'(a8), longint'(b8), cin8, sub8);
        if (prev_acc) nacc8++;
      end
    end
  end

  task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc, input logic xs);
    int n = 0;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    chk("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called just after the acceptance edge: result must show on the 4th edge
  task automatic check_latency4(input logic [15:0] es, input logic ec, input logic eo);
    for (int k = 0; k < 3; k++) begin
      chk("lat_early", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lit_sum", 32'(sum), 32'(es));
    chk("lit_cout", 32'(cout), 32'(ec));
    chk("lit_ovf", 32'(ovf), 32'(eo));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, a0;
    armed = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_out_valid8", 32'(out_valid8), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Carry ripples through every chunk
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    check_latency4(16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check_latency4(16'h8000, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    check_latency4(16'hFFFE, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    check_latency4(16'h7FFF, 1'b1, 1'b1);
    drain();

    // Back-to-back stream
    s0 = nout;
    for (int i = 0; i < 100; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      chk("stream_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    chk("stream_count", 32'(nout - s0), 32'd100);

    // Back-pressure: four beats fill the pipe, fifth waits
    s0 = nout;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'(16'h1111 * (i + 1)), 16'(16'h0F0F + i), 1'(i), 1'b0);
    @(negedge clk);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    a = 16'hABCD; b = 16'h1234; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stall_ready", 32'(in_ready), 32'd0);
      chk("bp_stall_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();
    chk("bp_count", 32'(nout - s0), 32'd5);

    // Random valid/ready toggling
    s0 = nout;
    a0 = nacc;
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(2) != 0);
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("rand_count", 32'(nout - s0), 32'(nacc - a0));

    // Reset with three beats in flight
    send(16'h0101, 16'h0202, 1'b0, 1'b0);
    send(16'h0303, 16'h0404, 1'b0, 1'b0);
    send(16'h0505, 16'h0606, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    send(16'd8, 16'd9, 1'b0, 1'b0);
    check_latency4(16'd17, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_extra", 32'(out_valid), 32'd0);
    end

    // 8-bit single-stage sweep
    a8 = 8'd128; b8 = 8'd128; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    chk("v8_lit_valid", 32'(out_valid8), 32'd1);
    chk("v8_lit_sum", 32'(sum8), 32'd0);
    chk("v8_lit_cout", 32'(cout8), 32'd1);
    chk("v8_lit_ovf", 32'(ovf8), 32'd1);
    a0 = nacc8;
    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 256; ib += 5) begin
        for (int m = 0; m < 3; m++) begin
          a8 = 8'(ia); b8 = 8'(ib); cin8 = (m == 1); sub8 = (m == 2);
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("v8_count", 32'(nacc8 - a0), 32'(256 * 52 * 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
